// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// This is a reusable inter-stage pipeline register with a valid/ready
// handshake. It has one main entry and one skid entry, a synchronous flush,
// and bubble insertion. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. Each boundary sets its own control and data widths.
//
// The main entry always drives the outputs. The skid entry catches the one
// bundle that arrives in the cycle the downstream stalls. This lets in_ready_o
// come from the state register alone, so there is no combinational path from
// out_ready_i to in_ready_o.
//
// Parameters
//   CTRL_W       width of the control bundle (zeroed on bubbles)
//   DATA_W       width of the data bundle
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_i        asynchronous reset, active low
//   flush_i      synchronous flush, discards every held entry
//   in_valid_i   upstream presents a valid bundle
//   in_ready_o   block can accept a bundle this cycle
//   in_ctrl_i    upstream control bundle
//   in_data_i    upstream data bundle
//   out_valid_o  block presents a valid bundle
//   out_ready_i  downstream accepts this cycle
//   out_ctrl_o   control bundle of the main entry, 0 while out_valid_o = 0
//   out_data_o   data bundle of the main entry (don't-care while not valid)
//   occupancy_o  number of valid entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    // The state encodes how many entries are valid. A separate valid bit per
    // entry is not needed, because the skid entry is only valid in FULL.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // This selects where the main entry loads from on the next edge.
    typedef enum logic [1:0] {
        MAIN_HOLD = 2'd0,
        MAIN_IN   = 2'd1,
        MAIN_SKID = 2'd2
    } main_sel_e;

    state_e            state_q;
    state_e            state_d;
    main_sel_e         main_sel;
    logic              skid_load;

    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    logic              in_fire;
    logic              out_fire;

    // -------------------------------------------------------------------------
    // Handshake decode. Every output here comes from registers only.
    // -------------------------------------------------------------------------
    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);

    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    // A bubble must not carry live RegWrite/MemWrite/Branch-type bits, so the
    // control bundle is gated. The data bundle is passed through ungated.
    assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
    assign out_data_o  = main_data_q;

    always_comb begin
        occupancy_o = 2'd0;
        case (state_q)
            ST_BUSY: occupancy_o = 2'd1;
            ST_FULL: occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state and load-enable logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through this block leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        main_sel  = MAIN_HOLD;
        skid_load = 1'b0;

        if (flush_i) begin
            // Flush overrides everything. An in_fire in this cycle is dropped.
            // An out_fire has already completed downstream, so it needs no
            // special handling.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_sel = MAIN_IN;
                        state_d  = ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        // Pass-through: the bundle leaving is replaced by the
                        // bundle arriving, so occupancy stays at 1.
                        main_sel = MAIN_IN;
                    end else if (in_fire) begin
                        // The downstream stalled while a bundle arrived. Park
                        // it in the skid entry so nothing upstream must react
                        // combinationally.
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end

                ST_FULL: begin
                    // in_ready_o is low here, so in_fire cannot occur.
                    if (out_fire) begin
                        main_sel = MAIN_SKID;
                        state_d  = ST_BUSY;
                    end
                end

                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: the datapath entries are reset as well as the state, because
        // out_data_o must read 0 straight out of reset. A valid bit alone
        // would not guarantee that.
        if (!rst_i) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else begin
            case (main_sel)
                MAIN_IN: begin
                    main_ctrl_q <= in_ctrl_i;
                    main_data_q <= in_data_i;
                end
                MAIN_SKID: begin
                    main_ctrl_q <= skid_ctrl_q;
                    main_data_q <= skid_data_q;
                end
                default: begin
                    main_ctrl_q <= main_ctrl_q;
                    main_data_q <= main_data_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (skid_load) begin
            skid_ctrl_q <= in_ctrl_i;
            skid_data_q <= in_data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
    a_state_legal : assert property (
        @(posedge clk_i) disable iff (!rst_i) state_q != 2'd3
    );

    a_no_accept_when_full : assert property (
        @(posedge clk_i) disable iff (!rst_i) (state_q == ST_FULL) |-> !in_fire
    );

    a_bubble_ctrl_zero : assert property (
        @(posedge clk_i) disable iff (!rst_i) !out_valid_o |-> (out_ctrl_o == '0)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// This bench drives pipe_stage_reg with a directed vector table, a few
// hand-written multi-cycle sequences, and a randomised run checked against a
// queue model.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 32;

    logic          clk;
    logic          rst_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [CW-1:0] in_ctrl_i;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [CW-1:0] out_ctrl_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    occupancy_o;

    pipe_stage_reg #(
        .CTRL_W (CW),
        .DATA_W (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each vector gives the inputs applied for one edge and the outputs
    // expected just after that edge.
    typedef struct {
        string         name;
        logic          flush;
        logic          in_valid;
        logic [CW-1:0] in_ctrl;
        logic [DW-1:0] in_data;
        logic          out_ready;
        logic          exp_valid;
        logic          exp_ready;
        logic [CW-1:0] exp_ctrl;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_occ;
    } vec_t;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } bundle_t;

    vec_t    vecs[$];
    bundle_t model_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic ev, input logic er,
                              input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                              input logic [1:0] eo, input logic cmp_data);
        check({name, ".valid"}, 64'(out_valid_o), 64'(ev));
        check({name, ".ready"}, 64'(in_ready_o),  64'(er));
        check({name, ".ctrl"},  64'(out_ctrl_o),  64'(ec));
        check({name, ".occ"},   64'(occupancy_o), 64'(eo));
        if (cmp_data) check({name, ".data"}, 64'(out_data_o), 64'(ed));
    endtask

    function automatic vec_t mk(input string nm, input logic fl, input logic iv,
                                input logic [CW-1:0] ic, input logic [DW-1:0] id,
                                input logic ordy, input logic ev, input logic er,
                                input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                                input logic [1:0] eo);
        vec_t v;
        v.name = nm; v.flush = fl; v.in_valid = iv; v.in_ctrl = ic; v.in_data = id;
        v.out_ready = ordy; v.exp_valid = ev; v.exp_ready = er; v.exp_ctrl = ec;
        v.exp_data = ed; v.exp_occ = eo;
        return v;
    endfunction

    task automatic drive(input logic fl, input logic iv, input logic [CW-1:0] ic,
                         input logic [DW-1:0] id, input logic ordy);
        flush_i     = fl;
        in_valid_i  = iv;
        in_ctrl_i   = ic;
        in_data_i   = id;
        out_ready_i = ordy;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0);

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b1, 8'h00, 32'h0, 2'd0, 1'b1);
        rst_i = 1'b1;

        // ---------------- table ----------------
        // Idle cycles in EMPTY stay in EMPTY.
        vecs.push_back(mk("idle", 0, 0, 8'hFF, 32'hDEAD, 1, 0, 1, 8'h00, 32'h0, 2'd0));
        // Back-to-back streaming. Every bundle appears one edge later.
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk($sformatf("stream%0d", i), 0, 1, CW'(i + 1), DW'(i), 1,
                              1, 1, CW'(i + 1), DW'(i), 2'd1));
        vecs.push_back(mk("drain", 0, 0, 8'h00, 32'h0, 1, 0, 1, 8'h00, 32'h0, 2'd0));
        // Stall: A loads, B skids, C is refused until the stall ends.
        vecs.push_back(mk("stA",  0, 1, 8'h21, 32'hA0, 0, 1, 1, 8'h21, 32'hA0, 2'd1));
        vecs.push_back(mk("stB",  0, 1, 8'h22, 32'hB0, 0, 1, 0, 8'h21, 32'hA0, 2'd2));
        vecs.push_back(mk("stC1", 0, 1, 8'h23, 32'hC0, 0, 1, 0, 8'h21, 32'hA0, 2'd2));
        vecs.push_back(mk("stC2", 0, 1, 8'h23, 32'hC0, 0, 1, 0, 8'h21, 32'hA0, 2'd2));
        vecs.push_back(mk("relB", 0, 1, 8'h23, 32'hC0, 1, 1, 1, 8'h22, 32'hB0, 2'd1));
        vecs.push_back(mk("relC", 0, 1, 8'h23, 32'hC0, 1, 1, 1, 8'h23, 32'hC0, 2'd1));
        // Hold in BUSY with no fire on either side.
        vecs.push_back(mk("hold", 0, 0, 8'h77, 32'h77, 0, 1, 1, 8'h23, 32'hC0, 2'd1));
        // Fill to FULL, then flush while upstream offers E.
        vecs.push_back(mk("fillD", 0, 1, 8'h24, 32'hD0, 0, 1, 0, 8'h23, 32'hC0, 2'd2));
        vecs.push_back(mk("flush", 1, 1, 8'h25, 32'hE0, 0, 0, 1, 8'h00, 32'h0, 2'd0));
        vecs.push_back(mk("postf", 0, 0, 8'h00, 32'h0, 1, 0, 1, 8'h00, 32'h0, 2'd0));
        // Flush in FULL with out_fire: the skid entry must not surface.
        vecs.push_back(mk("f2A", 0, 1, 8'h31, 32'h310, 0, 1, 1, 8'h31, 32'h310, 2'd1));
        vecs.push_back(mk("f2B", 0, 1, 8'h32, 32'h320, 0, 1, 0, 8'h31, 32'h310, 2'd2));
        vecs.push_back(mk("f2x", 1, 0, 8'h00, 32'h0,   1, 0, 1, 8'h00, 32'h0, 2'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_ctrl, vecs[i].in_data,
                  vecs[i].out_ready);
            @(posedge clk);
            #1;
            check_outs(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_ready, vecs[i].exp_ctrl,
                       vecs[i].exp_data, vecs[i].exp_occ, vecs[i].exp_valid);
        end

        // ---------------- flush with simultaneous out_fire in BUSY ----------------
        begin
            int seen;
            seen = 0;
            drive(1'b0, 1'b1, 8'h4F, 32'hF00D, 1'b0);
            @(posedge clk);
            #1;
            check_outs("fbF", 1'b1, 1'b1, 8'h4F, 32'hF00D, 2'd1, 1'b1);
            drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b1);
            // The bundle is taken at this edge. Count every accepted F.
            for (int c = 0; c < 4; c++) begin
                if (out_valid_o && out_ready_i && out_data_o == 32'hF00D) seen++;
                @(posedge clk);
                #1;
                drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
            end
            check("fb.once", 64'(seen), 64'd1);
            check_outs("fbE", 1'b0, 1'b1, 8'h00, 32'h0, 2'd0, 1'b0);
        end

        // ---------------- asynchronous reset mid-stream with occupancy 2 ----------------
        drive(1'b0, 1'b1, 8'h61, 32'h61, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 8'h62, 32'h62, 1'b0);
        @(posedge clk);
        #1;
        check("rm.occ2", 64'(occupancy_o), 64'd2);
        #2;
        rst_i = 1'b0;
        #1;
        check_outs("rm.async", 1'b0, 1'b1, 8'h00, 32'h0, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        drive(1'b0, 1'b1, 8'h5A, 32'h1234, 1'b1);
        @(posedge clk);
        #1;
        check_outs("rm.first", 1'b1, 1'b1, 8'h5A, 32'h1234, 2'd1, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        check_outs("rm.drain", 1'b0, 1'b1, 8'h00, 32'h0, 2'd0, 1'b0);

        // ---------------- random run against a queue model ----------------
        model_q.delete();
        begin
            int seq;
            seq = 1;
            for (int cyc = 0; cyc < 400; cyc++) begin
                logic    iv, ordy, fl, in_fire, out_fire;
                bundle_t b;
                check("rnd.valid", 64'(out_valid_o), 64'(model_q.size() > 0));
                check("rnd.ready", 64'(in_ready_o),  64'(model_q.size() < 2));
                check("rnd.occ",   64'(occupancy_o), 64'(model_q.size()));
                if (model_q.size() > 0) begin
                    check("rnd.ctrl", 64'(out_ctrl_o), 64'(model_q[0].ctrl));
                    check("rnd.data", 64'(out_data_o), 64'(model_q[0].data));
                end else begin
                    check("rnd.bubble", 64'(out_ctrl_o), 64'd0);
                end

                iv   = ($urandom_range(9) < 7);
                ordy = ($urandom_range(9) < 6);
                fl   = ($urandom_range(15) == 0);
                b.ctrl = CW'($urandom_range(255, 1));
                b.data = DW'(seq);
                drive(fl, iv, b.ctrl, b.data, ordy);

                in_fire  = iv && (model_q.size() < 2);
                out_fire = ordy && (model_q.size() > 0);
                if (in_fire) seq++;
                if (fl) begin
                    model_q.delete();
                end else begin
                    if (out_fire) void'(model_q.pop_front());
                    if (in_fire)  model_q.push_back(b);
                end
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
